keypad_scan: RTL and testbench

Matrix-keypad front end for the parking-meter controller. It drives the rows of a 4×4 keypad and samples its columns. It debounces the scan result and delivers the 4-bit key code `inputbottom` with the level `ispressed`, which feed `EDA3_control` directly. It also supplies a one-cycle `keystrobe` per accepted press.

---
 rtl/keypad_scan_if.sv | 33 +++
 rtl/keypad_scan.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad row/column lines and accepted-key outputs
// Signals:
//   col         - keypad columns, active-low
//   row         - keypad rows, active-low, one low at a time
//   inputbottom - accepted key code, 0 when no key is accepted
//   ispressed   - high while the accepted key is held
//   keystrobe   - one-cycle pulse per accepted press
// Modports:
//   master - the scanner (drives rows and key outputs, samples columns)
//   slave  - the keypad and its consumer
interface keypad_scan_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] inputbottom;
    logic       ispressed;
    logic       keystrobe;

    modport master (
        input  col,
        output row,
        output inputbottom,
        output ispressed,
        output keystrobe
    );

    modport slave (
        output col,
        input  row,
        input  inputbottom,
        input  ispressed,
        input  keystrobe
    );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with frame-based debounce
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   kp  - keypad_scan_if.master: samples col; drives row, inputbottom,
//         ispressed and keystrobe (all registered)
module keypad_scan #(
    parameter int CLK_DIV         = 2,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
    // Frame results are {mapped, code}; all-zero means "no key".
    localparam logic [4:0] RES_NONE = 5'd0;

    typedef enum logic {IDLE, PRESSED} state_t;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       step_q;
    logic [1:0]       hits_q;     // closures seen so far this frame, saturating at 2
    logic [4:0]       acc_q;      // key of the last closure seen this frame
    logic             frame_done_q;
    logic [4:0]       result_q;

    logic             sample;
    logic [2:0]       row_hits;
    logic [4:0]       row_key;
    logic [2:0]       hit_sum;
    logic [1:0]       hits_next;
    logic [4:0]       acc_next;
    logic [4:0]       frame_result;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       cand_q, cand_d;

    state_t           state_q, state_d;
    logic [3:0]       ib_q, ib_d;
    logic             pressed_q, pressed_d;
    logic             strobe_q, strobe_d;
    logic             press_go;
    logic             rel_go;

    function automatic logic [4:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] k;
        case ({r, c})
            4'h0:    k = {1'b1, 4'd1};
            4'h1:    k = {1'b1, 4'd2};
            4'h2:    k = {1'b1, 4'd3};
            4'h3:    k = {1'b1, 4'd10};
            4'h4:    k = {1'b1, 4'd4};
            4'h5:    k = {1'b1, 4'd5};
            4'h6:    k = {1'b1, 4'd6};
            4'h7:    k = {1'b1, 4'd11};
            4'h8:    k = {1'b1, 4'd7};
            4'h9:    k = {1'b1, 4'd8};
            4'hA:    k = {1'b1, 4'd9};
            4'hB:    k = {1'b1, 4'd12};
            4'hC:    k = RES_NONE;          // '*' is unused
            4'hD:    k = {1'b1, 4'd0};
            4'hE:    k = RES_NONE;          // '#' is unused
            4'hF:    k = {1'b1, 4'd13};
            default: k = RES_NONE;
        endcase
        return k;
    endfunction

    assign kp.row = ~(4'b0001 << step_q);
    assign sample = (div_q == DIV_LAST);

    // Closures on the row currently driven low.
    always_comb begin
        row_hits = 3'd0;
        row_key  = RES_NONE;
        for (int c = 0; c < 4; c++) begin
            if (!kp.col[c]) begin
                row_hits = row_hits + 3'd1;
                row_key  = key_map(step_q, 2'(c));
            end
        end
    end

    assign hit_sum   = {1'b0, hits_q} + row_hits;
    assign hits_next = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign acc_next  = (row_hits != 3'd0) ? row_key : acc_q;
    // Any second closure (mapped or not) voids the frame to reject ghost keys.
    assign frame_result = (hits_next == 2'd1 && acc_next[4]) ? acc_next : RES_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            step_q       <= 2'd0;
            hits_q       <= 2'd0;
            acc_q        <= RES_NONE;
            frame_done_q <= 1'b0;
            result_q     <= RES_NONE;
        end else begin
            frame_done_q <= 1'b0;
            if (sample) begin
                div_q  <= '0;
                step_q <= step_q + 2'd1;
                if (step_q == 2'd3) begin
                    hits_q       <= 2'd0;
                    acc_q        <= RES_NONE;
                    frame_done_q <= 1'b1;
                    result_q     <= frame_result;
                end else begin
                    hits_q <= hits_next;
                    acc_q  <= acc_next;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // Debounce: count consecutive identical frame results.
    always_comb begin
        cnt_d  = cnt_q;
        cand_d = cand_q;
        if (frame_done_q) begin
            if (result_q == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d  = CNT_W'(1);
                cand_d = result_q;
            end
        end
    end

    // The FSM sees the counter value after this frame's update.
    assign press_go = frame_done_q && (cnt_d == CNT_MAX) && cand_d[4];
    assign rel_go   = frame_done_q && (cnt_d == CNT_MAX) && (cand_d != {1'b1, ib_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            cand_q    <= RES_NONE;
            state_q   <= IDLE;
            ib_q      <= 4'd0;
            pressed_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            state_q   <= state_d;
            ib_q      <= ib_d;
            pressed_q <= pressed_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press_go) state_d = PRESSED;
            PRESSED: if (rel_go)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ib_d      = ib_q;
        pressed_d = pressed_q;
        strobe_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_go) begin
                    ib_d      = cand_d[3:0];
                    pressed_d = 1'b1;
                    strobe_d  = 1'b1;
                end
            end
            PRESSED: begin
                if (rel_go) begin
                    ib_d      = 4'd0;
                    pressed_d = 1'b0;
                end
            end
            default: begin
                ib_d      = 4'd0;
                pressed_d = 1'b0;
            end
        endcase
    end

    assign kp.inputbottom = ib_q;
    assign kp.ispressed   = pressed_q;
    assign kp.keystrobe   = strobe_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan
module tb_keypad_scan;
    localparam int N = 3;
    localparam logic [15:0] K_NONE = 16'h0000;
    localparam logic [15:0] K_1    = 16'h0001;
    localparam logic [15:0] K_2    = 16'h0002;
    localparam logic [15:0] K_3    = 16'h0004;
    localparam logic [15:0] K_A    = 16'h0008;
    localparam logic [15:0] K_5    = 16'h0020;
    localparam logic [15:0] K_C    = 16'h0800;
    localparam logic [15:0] K_STAR = 16'h1000;
    localparam logic [15:0] K_D    = 16'h8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] keys = K_NONE;   // bit r*4+c set = key at (r, c) held closed

    keypad_scan_if kp ();

    keypad_scan #(.CLK_DIV(2), .DEBOUNCE_FRAMES(N)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Keypad: a held key connects its row to its column.
    always_comb begin
        kp.col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.row[r]) kp.col[c] = 1'b0;
    end

    int key_code [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -1, 0, -1, 13};

    int checks = 0;
    int passes = 0;

    // Reference model state (frame level).
    int         m_cnt;
    int         m_cand;
    logic       m_pressed;
    logic [3:0] m_code;
    logic       m_strobe;
    logic       have_prev;
    int         prev_res;

    // Observation history.
    int   cyc = 0;
    int   strobes = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   low_run = 0;
    int   last_low_run = 0;
    logic prev_pr = 1'b0;
    logic seen_press = 1'b0;

    function automatic int frame_result(input logic [15:0] k);
        int n;
        int idx;
        n = 0;
        idx = 0;
        for (int j = 0; j < 16; j++) begin
            if (k[j]) begin
                n++;
                idx = j;
            end
        end
        if (n != 1) return -1;
        return key_code[idx];
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        m_cand    = -1;
        m_pressed = 1'b0;
        m_code    = 4'd0;
        m_strobe  = 1'b0;
        have_prev = 1'b0;
        prev_res  = -1;
        prev_pr   = 1'b0;
        low_run   = 0;
    endtask

    task automatic model_apply(input int res);
        if (res == m_cand) begin
            if (m_cnt < N) m_cnt++;
        end else begin
            m_cnt  = 1;
            m_cand = res;
        end
        m_strobe = 1'b0;
        if (!m_pressed && m_cnt == N && m_cand >= 0) begin
            m_pressed = 1'b1;
            m_code    = 4'(m_cand);
            m_strobe  = 1'b1;
        end else if (m_pressed && m_cnt == N && m_cand != int'(m_code)) begin
            m_pressed = 1'b0;
            m_code    = 4'd0;
        end
    endtask

    // Hold a key set for one whole frame, checking every cycle against the model.
    task automatic do_frame(input logic [15:0] k);
        logic [3:0] exp_row;
        logic [3:0] exp_ib;
        logic       exp_stb;
        keys = k;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            if (i == 1 && have_prev) model_apply(prev_res);
            @(negedge clk);
            cyc++;
            exp_row = 4'b1111;
            exp_row[(i / 2) % 4] = 1'b0;
            exp_ib  = m_pressed ? m_code : 4'd0;
            exp_stb = (i == 1) && m_strobe;
            checks++;
            if (kp.row !== exp_row) $display("FAIL row cyc=%0d got=%b want=%b", cyc, kp.row, exp_row);
            else passes++;
            checks++;
            if (kp.ispressed !== m_pressed) $display("FAIL ispressed cyc=%0d got=%b want=%b", cyc, kp.ispressed, m_pressed);
            else passes++;
            checks++;
            if (kp.inputbottom !== exp_ib) $display("FAIL inputbottom cyc=%0d got=%b want=%b", cyc, kp.inputbottom, exp_ib);
            else passes++;
            checks++;
            if (kp.keystrobe !== exp_stb) $display("FAIL keystrobe cyc=%0d got=%b want=%b", cyc, kp.keystrobe, exp_stb);
            else passes++;
            if (kp.keystrobe === 1'b1) strobes++;
            if (kp.ispressed === 1'b1) seen_press = 1'b1;
            if (kp.ispressed === 1'b1 && !prev_pr) begin
                rise_cyc     = cyc;
                last_low_run = low_run;
            end
            if (kp.ispressed !== 1'b1 && prev_pr) fall_cyc = cyc;
            if (kp.ispressed === 1'b1) low_run = 0;
            else low_run++;
            prev_pr = (kp.ispressed === 1'b1);
        end
        prev_res  = frame_result(k);
        have_prev = 1'b1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        keys = K_NONE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (kp.row !== 4'b1110) $display("FAIL reset_row got=%b want=1110", kp.row);
        else passes++;
        checks++;
        if (kp.ispressed !== 1'b0) $display("FAIL reset_ispressed got=%b want=0", kp.ispressed);
        else passes++;
        checks++;
        if (kp.inputbottom !== 4'd0) $display("FAIL reset_inputbottom got=%b want=0000", kp.inputbottom);
        else passes++;
        checks++;
        if (kp.keystrobe !== 1'b0) $display("FAIL reset_keystrobe got=%b want=0", kp.keystrobe);
        else passes++;
        rst = 1'b0;
        model_reset();
        repeat (2) do_frame(K_NONE);
    endtask

    task automatic test_clean_press();
        int s0;
        int t0;
        repeat (2) do_frame(K_NONE);
        s0 = strobes;
        t0 = cyc;
        repeat (8) do_frame(K_5);
        checks++;
        if (rise_cyc <= t0 || rise_cyc - t0 > 33) $display("FAIL press_latency got=%0d want<=33", rise_cyc - t0);
        else passes++;
        checks++;
        if (strobes - s0 != 1) $display("FAIL press_strobes got=%0d want=1", strobes - s0);
        else passes++;
        checks++;
        if (kp.inputbottom !== 4'b0101) $display("FAIL press_code got=%b want=0101", kp.inputbottom);
        else passes++;
        t0 = cyc;
        repeat (5) do_frame(K_NONE);
        checks++;
        if (fall_cyc <= t0 || fall_cyc - t0 > 33) $display("FAIL release_latency got=%0d want<=33", fall_cyc - t0);
        else passes++;
        checks++;
        if (kp.inputbottom !== 4'd0) $display("FAIL release_code got=%b want=0000", kp.inputbottom);
        else passes++;
    endtask

    task automatic test_bouncy();
        int s0;
        s0 = strobes;
        seen_press = 1'b0;
        do_frame(K_A);
        do_frame(K_NONE);
        do_frame(K_A);
        do_frame(K_NONE);
        checks++;
        if (seen_press || strobes != s0) $display("FAIL bounce_no_press got=%b want=0", seen_press);
        else passes++;
        repeat (5) do_frame(K_A);
        checks++;
        if (strobes - s0 != 1) $display("FAIL bounce_strobes got=%0d want=1", strobes - s0);
        else passes++;
        checks++;
        if (kp.inputbottom !== 4'b1010) $display("FAIL bounce_code got=%b want=1010", kp.inputbottom);
        else passes++;
        repeat (4) do_frame(K_NONE);
    endtask

    task automatic test_invalid();
        seen_press = 1'b0;
        repeat (6) do_frame(K_1 | K_2);
        checks++;
        if (seen_press) $display("FAIL ghost_press got=1 want=0");
        else passes++;
        repeat (4) do_frame(K_NONE);
        seen_press = 1'b0;
        repeat (6) do_frame(K_STAR);
        checks++;
        if (seen_press) $display("FAIL star_press got=1 want=0");
        else passes++;
        repeat (4) do_frame(K_NONE);
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = strobes;
        repeat (5) do_frame(K_3);
        checks++;
        if (kp.inputbottom !== 4'b0011) $display("FAIL change_first got=%b want=0011", kp.inputbottom);
        else passes++;
        repeat (6) do_frame(K_C);
        checks++;
        if (kp.inputbottom !== 4'b1100) $display("FAIL change_second got=%b want=1100", kp.inputbottom);
        else passes++;
        checks++;
        if (last_low_run != 8) $display("FAIL change_gap got=%0d want=8", last_low_run);
        else passes++;
        checks++;
        if (strobes - s0 != 2) $display("FAIL change_strobes got=%0d want=2", strobes - s0);
        else passes++;
        repeat (4) do_frame(K_NONE);
    endtask

    task automatic test_reset_mid_press();
        int s0;
        int t0;
        repeat (5) do_frame(K_D);
        checks++;
        if (kp.ispressed !== 1'b1 || kp.inputbottom !== 4'b1101) $display("FAIL mid_pre got=%b/%b want=1/1101", kp.ispressed, kp.inputbottom);
        else passes++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (kp.ispressed !== 1'b0) $display("FAIL mid_ispressed got=%b want=0", kp.ispressed);
        else passes++;
        checks++;
        if (kp.inputbottom !== 4'd0) $display("FAIL mid_inputbottom got=%b want=0000", kp.inputbottom);
        else passes++;
        checks++;
        if (kp.row !== 4'b1110) $display("FAIL mid_row got=%b want=1110", kp.row);
        else passes++;
        rst = 1'b0;
        model_reset();
        s0 = strobes;
        t0 = cyc;
        repeat (4) do_frame(K_D);
        checks++;
        if (rise_cyc - t0 != 25) $display("FAIL mid_relatch got=%0d want=25", rise_cyc - t0);
        else passes++;
        checks++;
        if (strobes - s0 != 1) $display("FAIL mid_strobe got=%0d want=1", strobes - s0);
        else passes++;
        repeat (4) do_frame(K_NONE);
    endtask

    task automatic test_random();
        logic [15:0] k;
        int len;
        for (int seg = 0; seg < 40; seg++) begin
            k = K_NONE;
            case ($urandom_range(0, 4))
                0: k = K_NONE;
                1, 2: k[$urandom_range(0, 15)] = 1'b1;
                3: begin
                    k[$urandom_range(0, 15)] = 1'b1;
                    k[$urandom_range(0, 15)] = 1'b1;
                end
                default: k[$urandom_range(12, 15)] = 1'b1;
            endcase
            len = $urandom_range(1, 5);
            repeat (len) do_frame(k);
        end
        repeat (4) do_frame(K_NONE);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bouncy();
        test_invalid();
        test_back_to_back();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
